vec_operand_loader: RTL and testbench

//  Serial-to-parallel operand stage directly upstream of the vector multiply/dot unit.

---
 rtl/vec_operand_loader.sv | 114 +++++++++++
 tb/tb_vec_operand_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_operand_loader.sv
// rtl/vec_operand_loader.sv - packs (a,b) element beats into zero-padded vector pairs
// One fill buffer plus one output register give full throughput across vector boundaries.
`ifndef FIXPOINT_WIDTH
`define FIXPOINT_WIDTH 16
`endif

module vec_operand_loader #(
  parameter  int VEC_SIZE = 16,
  parameter  int FW       = `FIXPOINT_WIDTH,
  localparam int IW       = $clog2(VEC_SIZE),
  localparam int CW       = $clog2(VEC_SIZE + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [FW-1:0]                i_elem_a,
  input  logic [FW-1:0]                i_elem_b,
  input  logic                         i_last,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [VEC_SIZE-1:0][FW-1:0]  o_vec_a,
  output logic [VEC_SIZE-1:0][FW-1:0]  o_vec_b,
  output logic [CW-1:0]                o_count
);

  logic [IW-1:0]               idx_q, idx_d;
  logic                        fill_full_q, fill_full_d;
  logic [CW-1:0]               fill_count_q, fill_count_d;
  logic [VEC_SIZE-1:0][FW-1:0] fill_a_q, fill_a_d;
  logic [VEC_SIZE-1:0][FW-1:0] fill_b_q, fill_b_d;
  logic                        out_valid_q, out_valid_d;
  logic [VEC_SIZE-1:0][FW-1:0] vec_a_q, vec_a_d;
  logic [VEC_SIZE-1:0][FW-1:0] vec_b_q, vec_b_d;
  logic [CW-1:0]               count_q, count_d;

  logic out_free;
  logic accept;
  logic complete;
  logic transfer;

  assign out_free   = !out_valid_q | i_out_ready;
  assign o_in_ready = !i_rst & (!fill_full_q | out_free);
  assign accept     = i_in_valid & o_in_ready;
  assign complete   = accept & (i_last | (idx_q == IW'(VEC_SIZE - 1)));
  assign transfer   = fill_full_q & out_free;

  assign o_out_valid = out_valid_q;
  assign o_vec_a     = vec_a_q;
  assign o_vec_b     = vec_b_q;
  assign o_count     = count_q;

  always_comb begin
    idx_d        = idx_q;
    fill_full_d  = fill_full_q;
    fill_count_d = fill_count_q;
    fill_a_d     = fill_a_q;
    fill_b_d     = fill_b_q;
    out_valid_d  = out_valid_q;
    vec_a_d      = vec_a_q;
    vec_b_d      = vec_b_q;
    count_d      = count_q;

    // Lanes past fill_count are masked on transfer, so stale fill lanes never leak.
    if (transfer) begin
      out_valid_d = 1'b1;
      count_d     = fill_count_q;
      fill_full_d = 1'b0;
      for (int l = 0; l < VEC_SIZE; l++) begin
        vec_a_d[l] = (CW'(l) < fill_count_q) ? fill_a_q[l] : '0;
        vec_b_d[l] = (CW'(l) < fill_count_q) ? fill_b_q[l] : '0;
      end
    end else if (out_valid_q && i_out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      fill_a_d[idx_q] = i_elem_a;
      fill_b_d[idx_q] = i_elem_b;
      if (complete) begin
        fill_full_d  = 1'b1;
        fill_count_d = CW'(idx_q) + CW'(1);
        idx_d        = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_q        <= '0;
      fill_full_q  <= 1'b0;
      fill_count_q <= '0;
      fill_a_q     <= '0;
      fill_b_q     <= '0;
      out_valid_q  <= 1'b0;
      vec_a_q      <= '0;
      vec_b_q      <= '0;
      count_q      <= '0;
    end else begin
      idx_q        <= idx_d;
      fill_full_q  <= fill_full_d;
      fill_count_q <= fill_count_d;
      fill_a_q     <= fill_a_d;
      fill_b_q     <= fill_b_d;
      out_valid_q  <= out_valid_d;
      vec_a_q      <= vec_a_d;
      vec_b_q      <= vec_b_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_vec_operand_loader.sv
// tb/tb_vec_operand_loader.sv - directed and random checks of vec_operand_loader against a queue model
`timescale 1ns/1ps
module tb_vec_operand_loader;
  localparam int VS = 4;
  localparam int FW = 16;
  localparam int CW = $clog2(VS + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   o_in_ready;
  logic [FW-1:0]          ea = '0;
  logic [FW-1:0]          eb = '0;
  logic                   last = 1'b0;
  logic                   o_out_valid;
  logic                   out_ready = 1'b0;
  logic [VS-1:0][FW-1:0]  vec_a;
  logic [VS-1:0][FW-1:0]  vec_b;
  logic [CW-1:0]          count;

  vec_operand_loader #(.VEC_SIZE(VS), .FW(FW)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .i_elem_a(ea), .i_elem_b(eb), .i_last(last), .o_out_valid(o_out_valid),
    .i_out_ready(out_ready), .o_vec_a(vec_a), .o_vec_b(vec_b), .o_count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VS*FW-1:0] a;
    logic [VS*FW-1:0] b;
    int               cnt;
  } vec_t;

  vec_t          exp_q[$];
  logic [FW-1:0] pa[$];
  logic [FW-1:0] pb[$];
  int            pending = 0;
  int            n_out = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic          last_acc = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: check at negedge against the model, then advance the model past the edge.
  task automatic step();
    logic acc, cons;
    vec_t v;
    @(negedge clk);
    acc  = in_valid & o_in_ready;
    cons = o_out_valid & out_ready;
    chk("in_ready", {127'd0, o_in_ready}, rst ? 128'd0 : {127'd0, !(pending == 2 && !out_ready)});
    if (cons) begin
      chk("vec_expected", {127'd0, exp_q.size() != 0}, 128'd1);
      if (exp_q.size() != 0) begin
        v = exp_q.pop_front();
        chk("out_vec_a", {64'd0, vec_a}, {64'd0, v.a});
        chk("out_vec_b", {64'd0, vec_b}, {64'd0, v.b});
        chk("out_count", {{(128-CW){1'b0}}, count}, 128'(v.cnt));
      end
      n_out++;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete(); pa.delete(); pb.delete(); pending = 0;
    end else begin
      if (cons) pending--;
      if (acc) begin
        pa.push_back(ea);
        pb.push_back(eb);
        if (last || pa.size() == VS) begin
          v.a = '0; v.b = '0; v.cnt = pa.size();
          for (int l = 0; l < pa.size(); l++) begin
            v.a[l*FW +: FW] = pa[l];
            v.b[l*FW +: FW] = pb[l];
          end
          exp_q.push_back(v);
          pa.delete(); pb.delete();
          pending++;
        end
      end
    end
    last_acc = acc;
  endtask

  task automatic send(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic l);
    int guard;
    in_valid = 1'b1; ea = a; eb = b; last = l;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!last_acc && guard < 100);
    if (!last_acc) chk("send_timeout", 128'(guard), 128'd0);
  endtask

  initial begin
    int base, drops;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {127'd0, o_out_valid}, 128'd0);
    chk("rst_count", {{(128-CW){1'b0}}, count}, 128'd0);
    chk("rst_vec_a", {64'd0, vec_a}, 128'd0);
    chk("rst_vec_b", {64'd0, vec_b}, 128'd0);

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(FW'(i + 1), FW'(i + 5), 1'b0);
    in_valid = 1'b0;
    chk("t1_not_yet", {127'd0, o_out_valid}, 128'd0);
    step();
    chk("t1_valid", {127'd0, o_out_valid}, 128'd1);
    chk("t1_vec_a", {64'd0, vec_a}, 128'h0004_0003_0002_0001);
    chk("t1_vec_b", {64'd0, vec_b}, 128'h0008_0007_0006_0005);
    chk("t1_count", {{(128-CW){1'b0}}, count}, 128'd4);
    step();
    chk("t1_one_cycle", {127'd0, o_out_valid}, 128'd0);

    send(16'd9, 16'd11, 1'b0);
    send(16'd10, 16'd12, 1'b1);
    in_valid = 1'b0;
    step();
    chk("t2_vec_a", {64'd0, vec_a}, 128'h0000_0000_000A_0009);
    chk("t2_count", {{(128-CW){1'b0}}, count}, 128'd2);
    send(16'd7, 16'd8, 1'b1);
    in_valid = 1'b0;
    step();
    chk("t2_fresh_a", {64'd0, vec_a}, 128'h0000_0000_0000_0007);
    chk("t2_fresh_cnt", {{(128-CW){1'b0}}, count}, 128'd1);
    step();

    out_ready = 1'b0;
    base = n_out;
    for (int i = 0; i < 8; i++) send(FW'($urandom), FW'($urandom), 1'b0);
    in_valid = 1'b1; ea = FW'($urandom); eb = FW'($urandom); last = 1'b0;
    step();
    chk("t3_stall_acc", {127'd0, last_acc}, 128'd0);
    chk("t3_stall_rdy", {127'd0, o_in_ready}, 128'd0);
    out_ready = 1'b1;
    send(ea, eb, 1'b0);
    for (int i = 0; i < 3; i++) send(FW'($urandom), FW'($urandom), 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t3_vectors", 128'(n_out - base), 128'd3);

    base = n_out;
    drops = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ea = FW'($urandom); eb = FW'($urandom); last = (i % 8 == 7);
      step();
      if (!last_acc) drops++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t4_no_stall", 128'(drops), 128'd0);
    chk("t4_vectors", 128'(n_out - base), 128'd10);

    send(16'h55, 16'h66, 1'b0);
    send(16'h57, 16'h68, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid", {127'd0, o_out_valid}, 128'd0);
    chk("t5_count", {{(128-CW){1'b0}}, count}, 128'd0);
    for (int i = 0; i < 4; i++) send(FW'(16'h21 + i), FW'(16'h31 + i), 1'b0);
    in_valid = 1'b0;
    step();
    chk("t5_vec_a", {64'd0, vec_a}, 128'h0024_0023_0022_0021);
    chk("t5_count4", {{(128-CW){1'b0}}, count}, 128'd4);
    step();

    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(FW'(16'h40 + i), FW'(16'h50 + i), 1'b0);
    in_valid = 1'b0;
    step();
    chk("t6_full_rdy", {127'd0, o_in_ready}, 128'd0);
    out_ready = 1'b1;
    #1;
    chk("t6_rdy_pulse", {127'd0, o_in_ready}, 128'd1);
    step();
    out_ready = 1'b0;
    #1;
    chk("t6_valid", {127'd0, o_out_valid}, 128'd1);
    chk("t6_vec_a", {64'd0, vec_a}, 128'h0047_0046_0045_0044);
    chk("t6_rdy_back", {127'd0, o_in_ready}, 128'd1);
    out_ready = 1'b1;
    step(); step();

    ea = FW'($urandom); eb = FW'($urandom); last = ($urandom % 5 == 0);
    for (int i = 0; i < 400; i++) begin
      if (last_acc || !in_valid) begin
        in_valid = ($urandom % 4 != 0);
        ea = FW'($urandom); eb = FW'($urandom); last = ($urandom % 5 == 0);
      end
      out_ready = ($urandom % 3 != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rand_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
